// File: rtl/csr_uart.sv
`default_nettype none
// ==== csr_uart: CSR-mapped 8N1 UART with TX/RX FIFOs, run-time divisor, sticky flags, level irq ====
// Rev 1.0
module csr_uart #(
   parameter logic [11:0] CSR_DATA   = 12'hbc0,
   parameter logic [11:0] CSR_STAT   = 12'hbc1,
   parameter logic [11:0] CSR_DIV    = 12'hbc2,
   parameter int          DEPTH_LOG2 = 3,
   parameter int          DIV_WIDTH  = 16,
   parameter int          DIV_RESET  = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic [2:0]  modify,
   input  logic [31:0] wdata,
   input  logic [11:0] addr,
   output logic [31:0] rdata,
   output logic        valid,
   output logic        tx,
   input  logic        rx,
   output logic        irq
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   logic [7:0]           tx_mem [DEPTH];
   logic [7:0]           rx_mem [DEPTH];
   logic [PW-1:0]        tx_wp, tx_rp, rx_wp, rx_rp;
   logic [DIV_WIDTH-1:0] div, div_new, div_clamped;
   logic                 rx_ie, tx_ie, rx_overrun, tx_drop, frame_err;

   uart_state_t          tx_st, rx_st;
   logic [DIV_WIDTH-1:0] tx_cnt, tx_div, rx_cnt, rx_div;
   logic [2:0]           tx_bit, rx_bit;
   logic [7:0]           tx_shift, rx_shift;
   logic                 rx_meta, rx_s, rx_prev;

   // Only the low data byte, the divisor field and the flag/enable bits are decoded.
   logic unused_wdata;
   assign unused_wdata = &{1'b0, wdata[31:DIV_WIDTH]};

   logic hit_data, hit_stat, hit_div, wr_any, acc;
   assign hit_data = (addr == CSR_DATA);
   assign hit_stat = (addr == CSR_STAT);
   assign hit_div  = (addr == CSR_DIV);
   assign wr_any   = (modify == 3'd1) || (modify == 3'd2) || (modify == 3'd3);
   assign acc      = (read || wr_any) && (hit_data || hit_stat || hit_div);

   logic tx_empty, tx_full, rx_empty, rx_full, rx_nonempty;
   assign tx_empty    = (tx_wp == tx_rp);
   assign tx_full     = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[PW-2:0] == tx_rp[PW-2:0]);
   assign rx_empty    = (rx_wp == rx_rp);
   assign rx_full     = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[PW-2:0] == rx_rp[PW-2:0]);
   assign rx_nonempty = ~rx_empty;

   logic tx_cnt_done, rx_cnt_done, rx_half;
   assign tx_cnt_done = (tx_cnt == tx_div - DIV_WIDTH'(1));
   assign rx_cnt_done = (rx_cnt == rx_div - DIV_WIDTH'(1));
   assign rx_half     = (rx_cnt == (rx_div >> 1) - DIV_WIDTH'(1));

   // A same-cycle FSM pop frees a slot, so a push into a full FIFO still lands.
   logic tx_pop, tx_push_req, tx_push, rx_pop, rx_stop_smp, rx_push_req, rx_push;
   assign tx_pop      = ~tx_empty && ((tx_st == S_IDLE) || (tx_st == S_STOP && tx_cnt_done));
   assign tx_push_req = hit_data && ((modify == 3'd1) || (modify == 3'd2));
   assign tx_push     = tx_push_req && (~tx_full || tx_pop);
   assign rx_pop      = read && hit_data && rx_nonempty;
   assign rx_stop_smp = (rx_st == S_STOP) && rx_cnt_done;
   assign rx_push_req = rx_stop_smp && rx_s;
   assign rx_push     = rx_push_req && (~rx_full || rx_pop);

   logic [31:0] data_rd, stat_rd, rd_value;
   assign data_rd  = rx_nonempty ? {1'b1, 23'd0, rx_mem[rx_rp[PW-2:0]]} : 32'd0;
   assign stat_rd  = {22'd0, tx_ie, rx_ie, 2'd0, frame_err, tx_drop, rx_overrun,
                      rx_nonempty, tx_empty, tx_full};
   assign rd_value = hit_data ? data_rd : (hit_stat ? stat_rd : 32'(div));

   always_comb begin
      div_new = div;
      case (modify)
         3'd1:    div_new = wdata[DIV_WIDTH-1:0];
         3'd2:    div_new = div | wdata[DIV_WIDTH-1:0];
         3'd3:    div_new = div & ~wdata[DIV_WIDTH-1:0];
         default: div_new = div;
      endcase
   end
   assign div_clamped = (div_new < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : div_new;

   logic clr_en;
   assign clr_en = hit_stat && ((modify == 3'd1) || (modify == 3'd3));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid      <= 1'b0;
         rdata      <= 32'd0;
         rx_ie      <= 1'b0;
         tx_ie      <= 1'b0;
         rx_overrun <= 1'b0;
         tx_drop    <= 1'b0;
         frame_err  <= 1'b0;
         div        <= DIV_WIDTH'(DIV_RESET);
      end else begin
         valid <= acc;
         rdata <= (acc && read) ? rd_value : 32'd0;
         if (hit_stat) begin
            case (modify)
               3'd1:    {tx_ie, rx_ie} <= wdata[9:8];
               3'd2:    {tx_ie, rx_ie} <= {tx_ie, rx_ie} | wdata[9:8];
               3'd3:    {tx_ie, rx_ie} <= {tx_ie, rx_ie} & ~wdata[9:8];
               default: ;
            endcase
         end
         // Hardware set wins over a simultaneous write-one-to-clear.
         rx_overrun <= (rx_overrun & ~(clr_en & wdata[3])) | (rx_push_req & ~rx_push);
         tx_drop    <= (tx_drop & ~(clr_en & wdata[4])) | (tx_push_req & ~tx_push);
         frame_err  <= (frame_err & ~(clr_en & wdata[5])) | (rx_stop_smp & ~rx_s);
         if (hit_div && wr_any) div <= div_clamped;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         tx_wp <= tx_wp + PW'(tx_push);
         tx_rp <= tx_rp + PW'(tx_pop);
         rx_wp <= rx_wp + PW'(rx_push);
         rx_rp <= rx_rp + PW'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[PW-2:0]] <= wdata[7:0];
      if (rx_push) rx_mem[rx_wp[PW-2:0]] <= rx_shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st    <= S_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
         tx_div   <= DIV_WIDTH'(DIV_RESET);
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         case (tx_st)
            S_IDLE: begin
               if (tx_pop) begin
                  tx_st    <= S_START;
                  tx       <= 1'b0;
                  tx_cnt   <= '0;
                  tx_div   <= div;
                  tx_shift <= tx_mem[tx_rp[PW-2:0]];
               end
            end
            S_START: begin
               if (tx_cnt_done) begin
                  tx_st  <= S_DATA;
                  tx     <= tx_shift[0];
                  tx_cnt <= '0;
                  tx_bit <= '0;
               end else tx_cnt <= tx_cnt + DIV_WIDTH'(1);
            end
            S_DATA: begin
               if (tx_cnt_done) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_st <= S_STOP;
                     tx    <= 1'b1;
                  end else begin
                     tx       <= tx_shift[1];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else tx_cnt <= tx_cnt + DIV_WIDTH'(1);
            end
            default: begin
               if (tx_cnt_done) begin
                  tx_cnt <= '0;
                  if (tx_pop) begin
                     tx_st    <= S_START;
                     tx       <= 1'b0;
                     tx_div   <= div;
                     tx_shift <= tx_mem[tx_rp[PW-2:0]];
                  end else tx_st <= S_IDLE;
               end else tx_cnt <= tx_cnt + DIV_WIDTH'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         rx_st    <= S_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DIV_WIDTH'(DIV_RESET);
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
         case (rx_st)
            S_IDLE: begin
               if (rx_prev && !rx_s) begin
                  rx_st  <= S_START;
                  rx_cnt <= '0;
                  rx_div <= div;
               end
            end
            S_START: begin
               // A line back high at mid start bit was only a glitch.
               if (rx_half) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_st  <= rx_s ? S_IDLE : S_DATA;
               end else rx_cnt <= rx_cnt + DIV_WIDTH'(1);
            end
            S_DATA: begin
               if (rx_cnt_done) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_st <= S_STOP;
                  else rx_bit <= rx_bit + 3'd1;
               end else rx_cnt <= rx_cnt + DIV_WIDTH'(1);
            end
            default: begin
               if (rx_cnt_done) begin
                  rx_cnt <= '0;
                  rx_st  <= S_IDLE;
               end else rx_cnt <= rx_cnt + DIV_WIDTH'(1);
            end
         endcase
      end
   end

   assign irq = (rx_ie & rx_nonempty) | (tx_ie & tx_empty);
endmodule
`default_nettype wire

// File: tb/tb_csr_uart.sv
`default_nettype none
// ==== tb_csr_uart: scoreboard bench for csr_uart CSR access, serial TX and RX ====
// Rev 1.0
module tb_csr_uart;
   localparam logic [11:0] A_DATA = 12'hbc0;
   localparam logic [11:0] A_STAT = 12'hbc1;
   localparam logic [11:0] A_DIV  = 12'hbc2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read = 1'b0;
   logic [2:0]  modify = 3'd0;
   logic [31:0] wdata = 32'd0;
   logic [11:0] addr = 12'd0;
   logic [31:0] rdata;
   logic        valid;
   logic        tx;
   logic        rx = 1'b1;
   logic        irq;

   always #5 clk = ~clk;

   csr_uart dut (
      .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
      .addr(addr), .rdata(rdata), .valid(valid), .tx(tx), .rx(rx), .irq(irq)
   );

   typedef struct {
      bit          rd;
      logic [31:0] val;
      string       tag;
   } acc_t;

   int          checks = 0;
   int          errors = 0;
   acc_t        acc_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   int          div_val = 868;
   bit          mon_busy = 1'b0;
   acc_t        mon_e;
   logic [7:0]  txb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic csr(input string tag, input logic rd, input logic [2:0] md,
                      input logic [11:0] a, input logic [31:0] wd, input logic [31:0] exp);
      acc_t e;
      @(negedge clk);
      read = rd; modify = md; addr = a; wdata = wd;
      if ((a == A_DATA || a == A_STAT || a == A_DIV) && (rd || (md >= 3'd1 && md <= 3'd3))) begin
         e.rd = rd; e.val = exp; e.tag = tag;
         acc_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      read = 1'b0; modify = 3'd0; addr = 12'd0; wdata = 32'd0;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] data_exp();
      if (rx_q.size() != 0) return {1'b1, 23'd0, rx_q.pop_front()};
      return 32'd0;
   endfunction

   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(negedge clk); rx = 1'b0;
      repeat (div_val - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); rx = b[i];
         repeat (div_val - 1) @(negedge clk);
      end
      @(negedge clk); rx = stop;
      repeat (div_val - 1) @(negedge clk);
      @(negedge clk); rx = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_tx(input int budget);
      int n = 0;
      while ((tx_q.size() != 0 || mon_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("tx_drain", 32'(tx_q.size()) | 32'(mon_busy), 32'd0);
   endtask

   // Every acknowledged access retires the oldest pending expectation.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (acc_q.size() == 0) check("valid_unexp", 32'(acc_q.size()), 32'd1);
         else begin
            mon_e = acc_q.pop_front();
            if (mon_e.rd) check(mon_e.tag, rdata, mon_e.val);
         end
      end
   end

   always begin
      @(negedge clk);
      if (tx === 1'b0 && !rst) begin
         mon_busy = 1'b1;
         repeat (div_val / 2) @(negedge clk);
         check("tx_start", 32'(tx), 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (div_val) @(negedge clk);
            txb[i] = tx;
         end
         repeat (div_val) @(negedge clk);
         check("tx_stop", 32'(tx), 32'd1);
         if (tx_q.size() == 0) check("tx_unexp", 32'(tx_q.size()), 32'd1);
         else check("tx_byte", 32'(txb), 32'(tx_q.pop_front()));
         mon_busy = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      csr("rst_stat", 1'b1, 3'd0, A_STAT, 32'd0, 32'h002);
      csr("rst_div", 1'b1, 3'd0, A_DIV, 32'd0, 32'd868);
      csr("div_wr8", 1'b0, 3'd1, A_DIV, 32'd8, 32'd0);
      idle(2);
      div_val = 8;

      // Single frame: tx falls on the second edge after the push cycle.
      csr("tx_a5", 1'b0, 3'd1, A_DATA, 32'hA5, 32'd0);
      tx_q.push_back(8'hA5);
      @(negedge clk);
      read = 1'b0; modify = 3'd0; addr = 12'd0; wdata = 32'd0;
      check("tx_lat1", 32'(tx), 32'd1);
      @(negedge clk);
      check("tx_lat2", 32'(tx), 32'd0);
      wait_tx(200);
      idle(2);

      // Ten back-to-back pushes: one starts, eight queue, the tenth drops.
      for (int i = 0; i < 10; i++) begin
         csr("tx_push", 1'b0, 3'd1, A_DATA, 32'h30 + 32'(i), 32'd0);
         if (i < 9) tx_q.push_back(8'(8'h30 + i));
      end
      csr("stat_full", 1'b1, 3'd0, A_STAT, 32'd0, 32'h011);
      idle(2);
      wait_tx(1200);
      csr("stat_drop", 1'b1, 3'd0, A_STAT, 32'd0, 32'h012);
      csr("drop_w1c", 1'b0, 3'd1, A_STAT, 32'h10, 32'd0);
      csr("stat_clr", 1'b1, 3'd0, A_STAT, 32'd0, 32'h002);
      idle(2);

      rx_q.push_back(8'h3C);
      send_rx(8'h3C, 1'b1);
      csr("rx_stat", 1'b1, 3'd0, A_STAT, 32'd0, 32'h006);
      csr("rx_data", 1'b1, 3'd0, A_DATA, 32'd0, data_exp());
      csr("rx_empty", 1'b1, 3'd0, A_DATA, 32'd0, data_exp());
      idle(2);

      send_rx(8'h55, 1'b0);
      csr("ferr_stat", 1'b1, 3'd0, A_STAT, 32'd0, 32'h022);
      csr("ferr_w1c", 1'b0, 3'd3, A_STAT, 32'h20, 32'd0);
      csr("ferr_clr", 1'b1, 3'd0, A_STAT, 32'd0, 32'h002);
      csr("ferr_data", 1'b1, 3'd0, A_DATA, 32'd0, data_exp());
      idle(2);

      @(negedge clk); rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      csr("glitch_stat", 1'b1, 3'd0, A_STAT, 32'd0, 32'h002);
      idle(2);

      for (int i = 0; i < 9; i++) begin
         if (i < 8) rx_q.push_back(8'(8'h81 + 3 * i));
         send_rx(8'(8'h81 + 3 * i), 1'b1);
      end
      csr("ovr_stat", 1'b1, 3'd0, A_STAT, 32'd0, 32'h00E);
      for (int i = 0; i < 9; i++) csr("ovr_data", 1'b1, 3'd0, A_DATA, 32'd0, data_exp());
      csr("ovr_w1c", 1'b0, 3'd1, A_STAT, 32'h08, 32'd0);
      csr("ovr_clr", 1'b1, 3'd0, A_STAT, 32'd0, 32'h002);
      idle(2);

      check("irq_off", 32'(irq), 32'd0);
      csr("txie_set", 1'b0, 3'd2, A_STAT, 32'h200, 32'd0);
      idle(1);
      check("irq_on", 32'(irq), 32'd1);
      csr("ie_stat", 1'b1, 3'd0, A_STAT, 32'd0, 32'h202);
      csr("div_wr2", 1'b0, 3'd1, A_DIV, 32'd2, 32'd0);
      csr("div_rw", 1'b1, 3'd1, A_DIV, 32'd16, 32'd4);
      csr("div_rd16", 1'b1, 3'd0, A_DIV, 32'd0, 32'd16);
      csr("div_clr", 1'b0, 3'd3, A_DIV, 32'hFFFF, 32'd0);
      csr("div_clamp", 1'b1, 3'd0, A_DIV, 32'd0, 32'd4);
      csr("unmapped", 1'b1, 3'd1, 12'h123, 32'hFF, 32'd0);
      csr("stat_end", 1'b1, 3'd0, A_STAT, 32'd0, 32'h202);
      idle(3);
      check("acc_left", 32'(acc_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/csr_uart.md
# csr_uart

Synthesizable CSR-mapped UART that replaces the simulation-only `$write` console on the pipeline's CSR bus. It provides 8N1 transmit and receive with parametrised FIFOs, a run-time baud divisor, sticky error flags and a level interrupt. It sits beside the CSR counter block, and its `valid`/`rdata` are OR-combined with the counter's.

## Interface
- `CSR_DATA`, 12'hbc0: TX push / RX pop register.
- `CSR_STAT`, 12'hbc1: status and interrupt-enable register.
- `CSR_DIV`, 12'hbc2: baud divisor register.
- `DEPTH_LOG2`, 3: each FIFO holds 2**DEPTH_LOG2 bytes.
- `DIV_WIDTH`, 16: width of the divisor.
- `DIV_RESET`, 868: divisor value after reset.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `read` in 1: CSR read strobe.
- `modify` in 3: CSR write mode. 1 = write, 2 = set, 3 = clear, any other value = no write.
- `wdata` in 32: CSR write data.
- `addr` in 12: CSR address.
- `rdata` out 32: read data. It is 0 unless `valid` is high.
- `valid` out 1: acknowledges an access to one of the three CSR addresses.
- `tx` out 1: serial output. Idles high.
- `rx` in 1: serial input. Asynchronous to `clk`.
- `irq` out 1: level interrupt.

## Operation
- **Access rules**
  - An access is any cycle with `read` set, or with `modify` in 1..3, and `addr` matching one of the three CSR addresses.
  - Accesses to any other address produce nothing.
  - A single access may both read and write (csrrw). In that case the read returns the pre-write value.
- **DATA register**
  - Read returns {rx_nonempty, 23'b0, head byte}. It pops the RX FIFO when it is nonempty.
  - Read with an empty RX FIFO returns 0 and pops nothing.
  - Modify 1 or 2 pushes `wdata[7:0]` into the TX FIFO.
  - A push to a full TX FIFO drops the byte and sets `tx_drop`.
- **STAT register layout**
  - bit0 `tx_full`, bit1 `tx_empty`, bit2 `rx_nonempty`.
  - bit3 `rx_overrun`, bit4 `tx_drop`, bit5 `frame_err`. All three are sticky.
  - bit8 `rx_ie`, bit9 `tx_ie`. Both are writable.
  - All other bits read 0.
- **STAT writes**
  - Modify 1 writes bits 9:8.
  - Modify 2 sets bits 9:8.
  - Modify 3 clears bits 9:8.
  - The sticky bits 5:3 clear when the corresponding `wdata` bit is 1 under modify 1 or 3. Modify 2 does not affect them.
- **DIV register**
  - Holds the bit period in clocks. Values below 4 are stored as 4.
  - Set and clear operate on the stored value.
  - A new value takes effect at the next frame start in each direction.
- **TX FSM**: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - IDLE leaves for START when the TX FIFO is nonempty. The pop happens on that transition.
  - Each state lasts DIV cycles.
  - At the end of STOP, the FSM goes directly to START if the FIFO is nonempty, so frames run back-to-back.
- **RX path**
  - `rx` passes through a 2-flop synchroniser.
  - FSM: IDLE → START → DATA → STOP.
  - IDLE leaves on a synchronised falling edge.
  - START samples at DIV/2 (integer division). If the line is high there, the event is a glitch and the FSM returns to IDLE.
  - DATA takes 8 samples, one every DIV cycles.
  - STOP samples one DIV later. If the stop bit is 0, `frame_err` is set and the byte is discarded.
  - If the stop bit is good but the RX FIFO is full, `rx_overrun` is set and the byte is discarded. Otherwise the byte is pushed.
  - The FSM returns to IDLE immediately after the stop sample.
- **Interrupt**: `irq` = (`rx_ie` & `rx_nonempty`) | (`tx_ie` & `tx_empty`). It is combinational from registers.
- **FIFOs**: circular buffers with DEPTH_LOG2+1-bit pointers. Full/empty is decided by the MSB difference.

## Timing
- **Reset values**
  - `tx`=1, `valid`=0, `rdata`=0, `irq`=0.
  - FIFOs empty, all sticky flags 0, both interrupt enables 0, DIV=DIV_RESET.
  - Both FSMs in IDLE.
- **Asserting `rst` mid-frame**: `tx` forces to 1 immediately (asynchronous), the frame is aborted and FIFO contents are lost.
- **CSR latency**
  - `valid` and `rdata` are registered and appear one cycle after the access cycle.
  - The state change (push, pop, register write) happens at the end of the access cycle.
- **TX start latency**: for a push at cycle N into an empty FIFO with TX idle, `tx` falls at edge N+2.
- **Frame length**: 10×DIV cycles.
- **RX latency**: a received byte is visible in STAT bit2 one cycle after the stop-bit sample.
- **Simultaneous events**
  - RX FIFO full, with a CPU pop and an RX push in the same cycle: both succeed, no overrun.
  - TX FIFO full, with a CPU push and an FSM pop in the same cycle: the push is accepted.
  - A sticky flag set by hardware in the same cycle as a W1C write stays set.

## Test plan
- **Reset and idle**: reset, then idle 20 cycles → `tx`=1, STAT reads 0x002, DIV reads DIV_RESET.
- **Single TX frame**: DIV=8, write 0xA5 to DATA → `tx` falls 2 cycles later; bits 1,0,1,0,0,1,0,1 LSB first, 8 cycles each; stop high; total 80 cycles.
- **TX overflow**: DIV=8, 10 back-to-back pushes with depth 8 → first byte starts, 8 queued, 10th dropped, `tx_drop`=1; W1C write of 0x10 clears it.
- **RX loopback**: drive 0x3C on `rx` at DIV=8 → STAT bit2=1; DATA reads 0x8000003C; the next DATA read returns 0.
- **RX errors**
  - Stop bit driven 0 → `frame_err`=1, FIFO stays empty.
  - 3-cycle low glitch → no byte, no error.
  - 9 frames without reads → `rx_overrun`=1, 8 bytes retained.
- **Interrupt and DIV clamp**: set `tx_ie` via modify 2 with TX empty → `irq`=1; write DIV=2 → reads back 4.
